// File: rtl/vga_timing_pkg.sv
// Default 800x480 raster timing constants shared by the VGA timing generator.
package vga_timing_pkg;

  localparam int H_SYNC_DEF  = 128;
  localparam int H_BACK_DEF  = 88;
  localparam int H_VALID_DEF = 800;
  localparam int H_FRONT_DEF = 40;
  localparam int V_SYNC_DEF  = 2;
  localparam int V_BACK_DEF  = 33;
  localparam int V_VALID_DEF = 480;
  localparam int V_FRONT_DEF = 10;

  localparam int H_TOTAL = H_SYNC_DEF + H_BACK_DEF + H_VALID_DEF + H_FRONT_DEF;
  localparam int V_TOTAL = V_SYNC_DEF + V_BACK_DEF + V_VALID_DEF + V_FRONT_DEF;
  localparam int H_ACT   = H_SYNC_DEF + H_BACK_DEF;
  localparam int V_ACT   = V_SYNC_DEF + V_BACK_DEF;

  localparam int         RGB_W         = 24;
  localparam logic [9:0] INVALID_COORD = 10'h3FF;

endpackage

// File: rtl/vga_ctrl_wrap_cnt.sv
// Modulus counter with enable; o_wrap flags the enabled clock on which it returns to 0.
module wrap_cnt
  import vga_timing_pkg::*;
#(
  parameter int WIDTH   = 11,
  parameter int MODULUS = 1056
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_cnt;
  logic             w_at_last;

  assign w_at_last = (r_cnt == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_wrap = i_en && w_at_last;

endmodule

// File: rtl/vga_ctrl.sv
// Raster timing generator: free-running h/v counters decoded into syncs, pixel
// requests one clock ahead of the visible window, and gated colour output.
module vga_ctrl
  import vga_timing_pkg::*;
#(
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BACK   = H_BACK_DEF,
  parameter int   H_VALID  = H_VALID_DEF,
  parameter int   H_FRONT  = H_FRONT_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BACK   = V_BACK_DEF,
  parameter int   V_VALID  = V_VALID_DEF,
  parameter int   V_FRONT  = V_FRONT_DEF,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [RGB_W-1:0] color_data_in,
  output logic             hsync,
  output logic             vsync,
  output logic             pix_data_req,
  output logic [9:0]       pix_x,
  output logic [9:0]       pix_y,
  output logic             rgb_valid,
  output logic [RGB_W-1:0] rgb,
  output logic             frame_end
);

  localparam int L_H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int L_V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
  localparam int L_H_ACT   = H_SYNC + H_BACK;
  localparam int L_V_ACT   = V_SYNC + V_BACK;

  logic [10:0] w_h_cnt;
  logic [9:0]  w_v_cnt;
  logic        w_h_wrap;
  logic        w_v_wrap;
  logic        w_h_vis;
  logic        w_h_req;
  logic        w_v_vis;

  wrap_cnt #(.WIDTH(11), .MODULUS(L_H_TOTAL)) u_h_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .i_en   (1'b1),
    .o_cnt  (w_h_cnt),
    .o_wrap (w_h_wrap)
  );

  // The vertical counter steps and wraps together with the horizontal wrap,
  // so its wrap flag marks the last clock of the frame.
  wrap_cnt #(.WIDTH(10), .MODULUS(L_V_TOTAL)) u_v_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .i_en   (w_h_wrap),
    .o_cnt  (w_v_cnt),
    .o_wrap (w_v_wrap)
  );

  assign w_h_vis = (w_h_cnt >= 11'(L_H_ACT)) && (w_h_cnt <= 11'(L_H_ACT + H_VALID - 1));
  assign w_h_req = (w_h_cnt >= 11'(L_H_ACT - 1)) && (w_h_cnt <= 11'(L_H_ACT + H_VALID - 2));
  assign w_v_vis = (w_v_cnt >= 10'(L_V_ACT)) && (w_v_cnt <= 10'(L_V_ACT + V_VALID - 1));

  assign hsync = (w_h_cnt < 11'(H_SYNC)) ? SYNC_POL : ~SYNC_POL;
  assign vsync = (w_v_cnt < 10'(V_SYNC)) ? SYNC_POL : ~SYNC_POL;

  assign rgb_valid    = w_h_vis && w_v_vis;
  assign pix_data_req = w_h_req && w_v_vis;

  // Coordinates lead the visible window by one clock so colour returns in time.
  assign pix_x = pix_data_req ? 10'(w_h_cnt - 11'(L_H_ACT - 1)) : INVALID_COORD;
  assign pix_y = pix_data_req ? 10'(w_v_cnt - 10'(L_V_ACT))     : INVALID_COORD;

  assign rgb       = rgb_valid ? color_data_in : '0;
  assign frame_end = w_v_wrap;

endmodule
